// File: rtl/encoder_cfg_scheduler.sv
// Run-time configuration scheduler for the encoder/angle-sync generator.
// Host configs are shadowed and committed only on a zero-mark boundary with the laser gated off.

module encoder_cfg_scheduler #(
   parameter int unsigned SETTLE_REVS  = 2,
   parameter logic [23:0] ZERO_TIMEOUT = 24'd5_000_000,
   parameter logic [1:0]  DEFAULT_RESO = 2'd2
) (
   input  logic        i_clk_50m,
   input  logic        i_rst,
   input  logic        i_cfg_req,
   input  logic [1:0]  i_cfg_reso,
   input  logic [1:0]  i_cfg_freq,
   input  logic        i_cfg_cal,
   input  logic        i_cfg_laser_en,
   input  logic [15:0] i_cfg_offset,
   output logic        o_cfg_ack,
   output logic        o_cfg_busy,
   input  logic        i_motor_state,
   input  logic        i_zero_sign,
   output logic [1:0]  o_reso_mode,
   output logic [1:0]  o_freq_mode,
   output logic        o_cal_mode,
   output logic [15:0] o_angle_offset,
   output logic        o_laser_mode,
   output logic        o_apply,
   output logic        o_fault,
   output logic [15:0] o_rev_cnt
);

   // state      | meaning
   // WAIT_MOTOR | motor not at speed; laser off, nothing commits
   // SETTLE     | counting zero marks after an apply or motor restart; laser off
   // RUN        | steady state; laser follows the active enable
   // PEND       | shadow set loaded, waiting for a zero mark to commit
   // FAULT      | zero-mark timeout; held until the motor drops

   typedef enum logic [2:0] {
      ST_WAIT_MOTOR,
      ST_SETTLE,
      ST_RUN,
      ST_PEND,
      ST_FAULT
   } state_t;

   localparam int unsigned SW = (SETTLE_REVS < 2) ? 1 : $clog2(SETTLE_REVS + 1);
   localparam state_t SETTLE_ENTRY = (SETTLE_REVS == 0) ? ST_RUN : ST_SETTLE;

   state_t        state_q;
   state_t        state_nxt;
   logic          accept;
   logic          commit;
   logic          timeout;
   logic          settle_done;
   logic          busy_nxt;
   logic          laser_nxt;
   logic [23:0]   to_cnt;
   logic [23:0]   to_inc;
   logic [SW-1:0] settle_cnt;
   logic          pend_q;

   logic [1:0]    sh_reso;
   logic [1:0]    sh_freq;
   logic          sh_cal;
   logic          sh_laser;
   logic [15:0]   sh_offset;
   logic          act_laser;

   always_comb begin
      to_inc      = (to_cnt == 24'hFF_FFFF) ? to_cnt : to_cnt + 24'd1;
      // a zero mark in the same cycle always beats the timeout
      timeout     = !i_zero_sign && (to_inc >= ZERO_TIMEOUT);
      settle_done = (32'(settle_cnt) + 32'd1) >= SETTLE_REVS;
      state_nxt   = state_q;
      accept      = 1'b0;
      commit      = 1'b0;

      case (state_q)
         ST_WAIT_MOTOR: begin
            if (i_motor_state)
               state_nxt = pend_q ? ST_PEND : SETTLE_ENTRY;
         end
         ST_SETTLE, ST_RUN: begin
            if (!i_motor_state)
               state_nxt = ST_WAIT_MOTOR;
            else if (timeout)
               state_nxt = ST_FAULT;
            else if (i_cfg_req && !o_cfg_busy) begin
               accept    = 1'b1;
               state_nxt = ST_PEND;
            end else if (state_q == ST_SETTLE && i_zero_sign && settle_done)
               state_nxt = ST_RUN;
         end
         ST_PEND: begin
            if (!i_motor_state)
               state_nxt = ST_WAIT_MOTOR;
            else if (timeout)
               state_nxt = ST_FAULT;
            else if (i_zero_sign) begin
               commit    = 1'b1;
               state_nxt = SETTLE_ENTRY;
            end
         end
         ST_FAULT: begin
            if (!i_motor_state)
               state_nxt = ST_WAIT_MOTOR;
         end
         default: state_nxt = ST_WAIT_MOTOR;
      endcase

      laser_nxt = (state_nxt == ST_RUN) && (commit ? sh_laser : act_laser);
      busy_nxt  = accept
                | (o_cfg_busy && (state_nxt != ST_RUN) && (state_nxt != ST_FAULT));
   end

   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         state_q        <= ST_WAIT_MOTOR;
         o_cfg_ack      <= 1'b0;
         o_cfg_busy     <= 1'b0;
         o_apply        <= 1'b0;
         o_fault        <= 1'b0;
         o_laser_mode   <= 1'b0;
         o_rev_cnt      <= 16'd0;
         o_reso_mode    <= DEFAULT_RESO;
         o_freq_mode    <= 2'd0;
         o_cal_mode     <= 1'b0;
         o_angle_offset <= 16'd0;
         act_laser      <= 1'b0;
         pend_q         <= 1'b0;
         sh_reso        <= 2'd0;
         sh_freq        <= 2'd0;
         sh_cal         <= 1'b0;
         sh_laser       <= 1'b0;
         sh_offset      <= 16'd0;
         to_cnt         <= 24'd0;
         settle_cnt     <= '0;
      end else begin
         state_q      <= state_nxt;
         o_cfg_ack    <= accept;
         o_apply      <= commit;
         o_cfg_busy   <= busy_nxt;
         o_laser_mode <= laser_nxt;
         o_fault      <= (state_nxt == ST_FAULT);

         if (accept) begin
            sh_reso   <= i_cfg_reso;
            sh_freq   <= i_cfg_freq;
            sh_cal    <= i_cfg_cal;
            sh_laser  <= i_cfg_laser_en;
            sh_offset <= i_cfg_offset;
            pend_q    <= 1'b1;
         end else if (commit || state_nxt == ST_FAULT) begin
            pend_q    <= 1'b0;
         end

         if (commit) begin
            o_reso_mode    <= sh_reso;
            o_freq_mode    <= sh_freq;
            o_cal_mode     <= sh_cal;
            o_angle_offset <= sh_offset;
            act_laser      <= sh_laser;
         end

         if (state_q != ST_SETTLE)
            settle_cnt <= '0;
         else if (i_zero_sign)
            settle_cnt <= settle_cnt + SW'(1);

         if (i_zero_sign || (state_q == ST_WAIT_MOTOR && state_nxt != ST_WAIT_MOTOR))
            to_cnt <= 24'd0;
         else if (state_q == ST_SETTLE || state_q == ST_RUN || state_q == ST_PEND)
            to_cnt <= to_inc;

         if (i_zero_sign && (state_q == ST_SETTLE || state_q == ST_RUN))
            o_rev_cnt <= o_rev_cnt + 16'd1;
      end
   end

endmodule
